neuron_sequencer: RTL and testbench

Control FSM that runs one full classification pass through the neuron calculator datapath. On a start pulse it clears the calculator accumulator and streams every pixel/weight word address to the image and weight memories. It asserts the calculator enable aligned to the memory read latency, then requests and latches the 1-bit classification result. It sits between the top-level host handshake (start/done) and the memories plus neuron calculator.

---
 rtl/neuron_sequencer.sv | 120 ++++++++++++
 tb/tb_neuron_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_sequencer.sv
// Control FSM for one classification pass: clears the neuron calculator, streams word
// addresses to the image/weight memories, aligns the accumulate enable to read latency,
// then requests and latches the 1-bit result.
module neuron_sequencer #(
  parameter int ADDR_WIDTH   = 12,
  parameter int NUM_WORDS    = 4096,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  output logic                  calc_reset,
  output logic                  calc_enable,
  output logic                  calc_get_result,
  input  logic                  calc_out,
  output logic                  busy,
  output logic                  done,
  output logic                  result
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    DRAIN,
    RESULT,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [1:0]            DRAIN_LAST = 2'(READ_LATENCY - 1);

  state_t                  state;
  logic [1:0]              drain_cnt;
  logic [READ_LATENCY-1:0] en_pipe;

  // The enable is the read strobe delayed through the pipe, so the calculator
  // accumulates exactly when the matching memory word arrives.
  assign calc_enable = en_pipe[READ_LATENCY-1];

  // NOTE: all state and outputs update with non-blocking assignments in one clocked
  // block, so every output is a flop and each branch reads pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      drain_cnt       <= '0;
      en_pipe         <= '0;
      mem_addr        <= '0;
      mem_rd_en       <= 1'b0;
      calc_reset      <= 1'b0;
      calc_get_result <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      result          <= 1'b0;
    end else begin
      en_pipe         <= (en_pipe << 1) | READ_LATENCY'(mem_rd_en);
      calc_reset      <= 1'b0;
      calc_get_result <= 1'b0;
      done            <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state      <= CLEAR;
            calc_reset <= 1'b1;
            busy       <= 1'b1;
            mem_addr   <= '0;
          end
        end

        CLEAR: begin
          state     <= FETCH;
          mem_rd_en <= 1'b1;
          mem_addr  <= '0;
        end

        // Terminal test on the current address, never on the incremented value, so a
        // full 2^ADDR_WIDTH image ends at all-ones without wrapping.
        FETCH: begin
          if (mem_addr == LAST_ADDR) begin
            state     <= DRAIN;
            mem_rd_en <= 1'b0;
            drain_cnt <= '0;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end

        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state           <= RESULT;
            calc_get_result <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        RESULT: begin
          state  <= DONE;
          result <= calc_out;
          done   <= 1'b1;
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          mem_rd_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Scoreboard bench for neuron_sequencer: three instances cover nominal, latency-3 and
// full-depth configurations; a negedge monitor checks every pass against queued expectations.
module tb_neuron_sequencer;

  typedef struct {
    int creset;
    int en_first;
    int getres;
    int done;
    int words;
    bit res;
  } txn_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start     [3];
  logic        calc_out  [3];
  logic [11:0] mem_addr  [3];
  logic        rd        [3];
  logic        cr        [3];
  logic        en        [3];
  logic        gr        [3];
  logic        bz        [3];
  logic        dn        [3];
  logic        rs        [3];

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   sel    = 0;
  txn_t exp_q[$];

  always #5 clock = ~clock;

  neuron_sequencer #(.ADDR_WIDTH(12), .NUM_WORDS(4), .READ_LATENCY(1)) u_nom (
    .clock(clock), .reset(reset), .start(start[0]), .mem_addr(mem_addr[0]),
    .mem_rd_en(rd[0]), .calc_reset(cr[0]), .calc_enable(en[0]),
    .calc_get_result(gr[0]), .calc_out(calc_out[0]), .busy(bz[0]), .done(dn[0]),
    .result(rs[0]));

  neuron_sequencer #(.ADDR_WIDTH(12), .NUM_WORDS(4), .READ_LATENCY(3)) u_lat3 (
    .clock(clock), .reset(reset), .start(start[1]), .mem_addr(mem_addr[1]),
    .mem_rd_en(rd[1]), .calc_reset(cr[1]), .calc_enable(en[1]),
    .calc_get_result(gr[1]), .calc_out(calc_out[1]), .busy(bz[1]), .done(dn[1]),
    .result(rs[1]));

  neuron_sequencer #(.ADDR_WIDTH(12), .NUM_WORDS(4096), .READ_LATENCY(1)) u_full (
    .clock(clock), .reset(reset), .start(start[2]), .mem_addr(mem_addr[2]),
    .mem_rd_en(rd[2]), .calc_reset(cr[2]), .calc_enable(en[2]),
    .calc_get_result(gr[2]), .calc_out(calc_out[2]), .busy(bz[2]), .done(dn[2]),
    .result(rs[2]));

  function automatic int nw(int i);
    return (i == 2) ? 4096 : 4;
  endfunction

  function automatic int rl(int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic int outs(int i);
    return int'({mem_addr[i], rd[i], cr[i], en[i], gr[i], bz[i], dn[i], rs[i]});
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Expected timeline for a pass whose start is sampled in cycle s.
  task automatic push_txn(input int i, input int s, input bit r);
    txn_t t;
    t.creset   = s + 1;
    t.en_first = s + 2 + rl(i);
    t.getres   = s + nw(i) + rl(i) + 2;
    t.done     = s + nw(i) + rl(i) + 3;
    t.words    = nw(i);
    t.res      = r;
    exp_q.push_back(t);
  endtask

  task automatic start_pass(input int i, input bit r);
    @(posedge clock); #1;
    start[i]    = 1'b1;
    calc_out[i] = r;
    push_txn(i, cyc, r);
    @(posedge clock); #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    check("pass_completed_in_budget", exp_q.size(), 0);
    repeat (4) @(posedge clock);
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor: tracks the selected instance and scores each done against the queue.
  initial begin
    int   next_addr = 0;
    int   rd_cnt    = 0;
    int   en_cnt    = 0;
    int   en_runs   = 0;
    int   en_first  = -1;
    int   m_creset  = -1;
    int   m_getres  = -1;
    bit   en_prev   = 1'b0;
    txn_t t;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (cr[sel]) begin
          m_creset  = cyc;
          next_addr = 0;
          rd_cnt    = 0;
          en_cnt    = 0;
          en_runs   = 0;
          en_first  = -1;
        end
        if (rd[sel]) begin
          check("fetch_addr", int'(mem_addr[sel]), next_addr);
          next_addr++;
          rd_cnt++;
        end
        if (en[sel]) begin
          if (!en_prev) begin
            en_runs++;
            if (en_first < 0) en_first = cyc;
          end
          en_cnt++;
        end
        en_prev = en[sel];
        if (gr[sel]) m_getres = cyc;
        if (dn[sel]) begin
          check("done_was_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            check("done_cycle", cyc, t.done);
            check("calc_reset_cycle", m_creset, t.creset);
            check("get_result_cycle", m_getres, t.getres);
            check("enable_first_cycle", en_first, t.en_first);
            check("enable_count", en_cnt, t.words);
            check("enable_runs", en_runs, 1);
            check("read_count", rd_cnt, t.words);
            check("result", int'(rs[sel]), int'(t.res));
          end
        end
      end else begin
        en_prev = 1'b0;
      end
    end
  end

  initial begin
    int  s;
    bit  found;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i]    = 1'b0;
      calc_out[i] = 1'b0;
    end

    // Reset then idle.
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) check($sformatf("idle_outputs_dut%0d", i), outs(i), 0);
    end

    // Nominal passes with both result values.
    sel = 0;
    start_pass(0, 1'b1);
    wait_drain(100);
    @(negedge clock);
    check("result_held_in_idle", int'(rs[0]), 1);
    start_pass(0, 1'b0);
    wait_drain(100);

    // Read latency 3.
    sel = 1;
    start_pass(1, 1'b1);
    wait_drain(100);

    // Starts while busy are ignored.
    sel = 0;
    @(posedge clock); #1;
    start[0] = 1'b1; calc_out[0] = 1'b1;
    push_txn(0, cyc, 1'b1);
    @(posedge clock); #1 start[0] = 1'b0;
    repeat (2) @(posedge clock); #1 start[0] = 1'b1;
    @(posedge clock); #1 start[0] = 1'b0;
    repeat (2) @(posedge clock); #1 start[0] = 1'b1;
    @(posedge clock); #1 start[0] = 1'b0;
    wait_drain(100);
    repeat (20) @(posedge clock);
    @(negedge clock);
    check("idle_after_ignored_starts", int'(bz[0]), 0);

    // Start held high: back-to-back passes through IDLE then CLEAR.
    @(posedge clock); #1;
    s = cyc;
    start[0] = 1'b1; calc_out[0] = 1'b0;
    push_txn(0, s, 1'b0);
    push_txn(0, s + nw(0) + rl(0) + 4, 1'b1);
    repeat (10) @(posedge clock); #1 calc_out[0] = 1'b1;
    repeat (2) @(posedge clock); #1 start[0] = 1'b0;
    wait_drain(100);

    // Reset mid-FETCH at address 2.
    @(posedge clock); #1 start[0] = 1'b1;
    @(posedge clock); #1 start[0] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clock);
      if (rd[0] && mem_addr[0] == 12'd2) found = 1'b1;
    end
    check("reached_addr2", int'(found), 1);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("outputs_after_midpass_reset", outs(0), 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("no_enable_after_reset", int'(en[0]), 0);
      check("no_done_after_reset", int'(dn[0]), 0);
    end
    start_pass(0, 1'b1);
    wait_drain(100);

    // Full depth: 4096 words, no address wrap.
    sel = 2;
    start_pass(2, 1'b1);
    wait_drain(5000);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
